// File: rtl/oc8051_prog_mem.sv
// oc8051 in-system-loadable program memory.
// Registered 3-byte fetch window with req/ack handshake and wait states.
module oc8051_prog_mem #(
  parameter int INT_ROM_WID = 7,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            addr,
  input  logic                   fetch_req,
  output logic                   ea_int,
  output logic [7:0]             data1,
  output logic [7:0]             data2,
  output logic [7:0]             data3,
  output logic                   fetch_ack,
  output logic                   busy,
  input  logic                   prog_en,
  input  logic                   prog_wr,
  input  logic [7:0]             prog_data,
  output logic [INT_ROM_WID-1:0] prog_ptr
);

  localparam int DEPTH = 1 << INT_ROM_WID;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;
  localparam logic [3:0] L_WS = 4'(WAIT_STATES);
  localparam logic [INT_ROM_WID-1:0] L_ONE = 1;
  localparam logic [INT_ROM_WID-1:0] L_TWO = 2;

  logic [7:0]             r_mem [DEPTH];
  logic [0:0]             r_state;
  logic [3:0]             r_cnt;
  logic [INT_ROM_WID-1:0] r_addr_q;
  logic [INT_ROM_WID-1:0] r_ptr;
  logic                   r_pen_q;
  logic                   r_ack;
  logic [7:0]             r_d1;
  logic [7:0]             r_d2;
  logic [7:0]             r_d3;

  logic                   w_rise;
  logic                   w_we;
  logic [INT_ROM_WID-1:0] w_wptr;
  logic [INT_ROM_WID-1:0] w_a1;
  logic [INT_ROM_WID-1:0] w_a2;

  assign ea_int = (addr[15:INT_ROM_WID] == '0);
  assign w_rise = prog_en & ~r_pen_q;
  assign w_we   = prog_en & prog_wr;
  assign w_wptr = w_rise ? '0 : r_ptr;
  assign w_a1   = r_addr_q + L_ONE;
  assign w_a2   = r_addr_q + L_TWO;

  assign data1     = r_d1;
  assign data2     = r_d2;
  assign data3     = r_d3;
  assign fetch_ack = r_ack;
  assign prog_ptr  = r_ptr;
  assign busy      = (r_state == ST_READ) | prog_en;

  // Array is deliberately not reset so a loaded image survives rst.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wptr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_pen_q <= 1'b0;
    end else begin
      r_pen_q <= prog_en;
      if (w_we) begin
        r_ptr <= w_wptr + L_ONE;
      end else if (w_rise) begin
        r_ptr <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_addr_q <= '0;
      r_ack    <= 1'b0;
      r_d1     <= 8'h00;
      r_d2     <= 8'h00;
      r_d3     <= 8'h00;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fetch_req && ea_int && !prog_en) begin
            r_addr_q <= addr[INT_ROM_WID-1:0];
            r_cnt    <= L_WS;
            r_state  <= ST_READ;
          end
        end
        default: begin
          if (prog_en) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_d1    <= r_mem[r_addr_q];
            r_d2    <= r_mem[w_a1];
            r_d3    <= r_mem[w_a2];
            r_ack   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/oc8051_prog_mem.md
# oc8051_prog_mem

Parametrised, in-system-loadable on-chip program memory for the oc8051 core. It replaces the fixed 128-byte LUT ROM with a byte array of depth 2^INT_ROM_WID. It returns a registered three-byte instruction window (the bytes at addr, addr+1 and addr+2) through a request/acknowledge handshake with configurable wait states. A byte-serial programming port fills the array at run time.

## Interface
- INT_ROM_WID, 7: internal address width; depth = 2^INT_ROM_WID bytes, legal range 7..15.
- WAIT_STATES, 0: extra cycles inserted between accepting a fetch and acknowledging it; legal range 0..15.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  16  fetch address (program counter).
- fetch_req  input  1  fetch request, level; sampled only in IDLE.
- ea_int  output  1  combinational; 1 when addr[15:INT_ROM_WID] == 0, i.e. the address is internal.
- data1, data2, data3  output  8 each  bytes at addr_q, addr_q+1 and addr_q+2, each modulo depth.
- fetch_ack  output  1  one-cycle pulse; data1..3 are valid from this cycle on.
- busy  output  1  1 while a fetch is in flight or while programming is active.
- prog_en  input  1  programming mode enable.
- prog_wr  input  1  write strobe; prog_data is written when it is high.
- prog_data  input  8  byte to be written.
- prog_ptr  output  INT_ROM_WID  next write address.

## Operation
- States: IDLE, READ.
- IDLE -> READ happens when fetch_req=1, ea_int=1 and prog_en=0. On that edge:
  - addr[INT_ROM_WID-1:0] is latched into addr_q;
  - the wait counter is loaded with WAIT_STATES.
- READ with cnt != 0: decrement cnt and stay in READ.
- READ with cnt == 0: on the next edge,
  - register mem[addr_q], mem[addr_q+1] and mem[addr_q+2] into data1..3;
  - pulse fetch_ack;
  - return to IDLE.
- Address arithmetic is INT_ROM_WID bits wide and wraps. With depth 128, addr_q=0x7F gives bytes 0x7F, 0x00, 0x01.
- A fetch_req with ea_int=0 is ignored: no state change, no ack. The external bus path serves that address.
- Changes on addr after acceptance have no effect. addr_q is the only address used.
- data1..3 hold their value until the next fetch_ack.
- Programming:
  - A rising edge of prog_en (prog_en=1 and registered prog_en_q=0) clears prog_ptr to 0.
  - Each cycle with prog_en=1 and prog_wr=1 writes prog_data to mem[prog_ptr] and increments prog_ptr. prog_ptr wraps from depth-1 to 0.
  - prog_wr is ignored while prog_en=0.
  - prog_ptr holds its value after prog_en falls.
- prog_en=1 while in READ aborts the fetch: state goes to IDLE on the next edge, no fetch_ack is issued, and data1..3 are unchanged.
- fetch_req is not accepted while prog_en=1. It is accepted from the first cycle that prog_en=0.
- A write and a read of the same byte never coincide, because reads are blocked during programming.
- busy = (state == READ) | prog_en.
- Memory contents are not reset. Contents written before a reset survive it.

## Timing
- Reset values: data1=data2=data3=8'h00, fetch_ack=0, busy=0 (prog_en permitting), prog_ptr=0, state IDLE, cnt=0, prog_en_q=0.
- Latency: request sampled at edge k; fetch_ack is high during the cycle after edge k+1+WAIT_STATES.
- Throughput: fetch_ack coincides with IDLE, so a new request can be accepted on the edge that ends the ack cycle. This gives one fetch per WAIT_STATES+2 cycles.
- fetch_ack is never high for two consecutive cycles.
- Reset asserted mid-fetch forces IDLE immediately and clears the outputs asynchronously; no ack follows after reset is released.
- Write latency: a byte written at edge n is readable by a fetch accepted at edge n+1 or later.

## Test plan
- Program, then fetch (INT_ROM_WID=7, WAIT_STATES=0): pulse prog_en, write 8'h02, 8'h00, 8'h40, 8'h75, drop prog_en, then fetch addr=0.
  - Required: ack one cycle after the accept edge; data1..3 = 02, 00, 40; prog_ptr=4.
- Wrap-around: write 8'hAA at 0x7F and 8'hBB at 0x00 (via a 129-byte load), then fetch addr=0x007F.
  - Required: data1=AA, data2=BB, data3=mem[1].
- Wait states: WAIT_STATES=2, fetch addr=1 held high, addr changed the cycle after accept.
  - Required: ack 3 cycles after the accept edge with the bytes of addr 1; next ack follows 4 cycles later.
- External address: addr=0x0080 with fetch_req=1.
  - Required: ea_int=0; no ack, busy=0, data unchanged for 10 cycles.
- Abort: WAIT_STATES=3, raise prog_en one cycle after accept.
  - Required: state returns to IDLE, no ack, data unchanged, prog_ptr=0, busy=1 while prog_en is high.
- Reset mid-fetch: assert rst during READ.
  - Required: data1..3=00, fetch_ack=0 immediately; after release, no ack until a new request; previously programmed bytes still read back correctly.
